// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: instruction fetch and data load/store share one memory port.
// Round-robin grant, registered bus outputs, wait-state timeout and illegal-size rejection.
module bus_arbiter #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] PC_ORIGIN = 32'h10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        mem_ack_n,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        i_ack,
    output logic        d_ack,
    output logic [31:0] i_rdata,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        stall
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       last_data;
    logic       i_pend;
    logic       d_pend;
    logic       grant_i;
    logic       grant_d;
    logic       timeout_hit;

    // A requester whose ack is on the wires this cycle is still holding its
    // request; masking it lets the ack cycle grant the other side immediately.
    always_comb begin
        i_pend      = i_req & ~i_ack;
        d_pend      = d_req & ~d_ack;
        grant_d     = d_pend & (~i_pend | ~last_data);
        grant_i     = i_pend & ~grant_d;
        timeout_hit = (wait_cnt == TIMEOUT_LAST);
        stall       = (i_req & ~i_ack) | (d_req & ~d_ack);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            last_data <= 1'b0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= PC_ORIGIN;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        last_data <= 1'b1;
                        if (d_size == 2'b11) begin
                            state   <= S_ERR;
                            d_ack   <= 1'b1;
                            bus_err <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            state     <= S_DATA;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_write <= d_write;
                            mem_size  <= d_size;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end
                    end else if (grant_i) begin
                        last_data <= 1'b0;
                        state     <= S_FETCH;
                        wait_cnt  <= '0;
                        mem_req   <= 1'b1;
                        mem_write <= 1'b0;
                        mem_size  <= '0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                S_FETCH, S_DATA: begin
                    if (!mem_ack_n || timeout_hit) begin
                        // Ack wins over timeout in the same cycle; abort returns zero data.
                        state     <= S_IDLE;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        mem_size  <= '0;
                        mem_addr  <= PC_ORIGIN;
                        mem_wdata <= '0;
                        bus_err   <= mem_ack_n;
                        if (state == S_FETCH) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ack_n ? '0 : mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_ack_n ? '0 : mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ERR: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
